// File: rtl/exec_simd_pipe.sv
// Two-stage signed SIMD vector ALU for the GPU execute stage: add/sub/mul with optional
// saturation and per-lane overflow, min/max, ReLU and arithmetic shift, with valid/ready on both sides.
module exec_simd_pipe #(
   parameter int LANES = 4,
   parameter int LW    = 16,
   parameter int SHW   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          opcode,
   input  logic                sat,
   input  logic [LANES*LW-1:0] a,
   input  logic [LANES*LW-1:0] b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LANES*LW-1:0] result,
   output logic [LANES-1:0]    ovf,
   output logic                err
);

   // Raw per-lane results are carried at double width so ADD/SUB/MUL stay exact into S2.
   localparam int XW = 2 * LW;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_MAX  = 4'h3;
   localparam logic [3:0] OP_RELU = 4'h4;
   localparam logic [3:0] OP_MIN  = 4'h5;
   localparam logic [3:0] OP_SRA  = 4'h6;

   logic                en1, en2;
   logic                s1_valid;
   logic [3:0]          s1_op;
   logic                s1_sat;
   logic                s1_arith;
   logic [LANES*LW-1:0] res_n;
   logic [LANES-1:0]    ovf_n;
   logic                err_n;

   assign en2      = !out_valid || out_ready;
   assign en1      = !s1_valid || en2;
   assign in_ready = en1;

   assign s1_arith = (s1_op == OP_ADD) || (s1_op == OP_SUB) || (s1_op == OP_MUL);
   assign err_n    = (s1_op > OP_SRA);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [XW-1:0] ax, bx, raw_n, s1_raw;
      logic                 lane_ovf;

      assign ax = XW'($signed(a[i*LW +: LW]));
      assign bx = XW'($signed(b[i*LW +: LW]));

      always_comb begin
         // NOTE: default assigned first so every path writes raw_n and no latch is inferred.
         raw_n = '0;
         case (opcode)
            OP_ADD:  raw_n = ax + bx;
            OP_SUB:  raw_n = ax - bx;
            OP_MUL:  raw_n = ax * bx;
            OP_MAX:  raw_n = (ax > bx) ? ax : bx;
            OP_RELU: raw_n = (!ax[XW-1] && (|ax)) ? ax : '0;
            OP_MIN:  raw_n = (ax < bx) ? ax : bx;
            OP_SRA:  raw_n = ax >>> b[i*LW +: SHW];
            default: raw_n = '0;
         endcase
      end

      // NOTE: datapath payload has no reset; only the valid bits need a defined value after reset.
      always_ff @(posedge clk) begin
         if (en1 && in_valid) s1_raw <= raw_n;
      end

      // Exact value fits in LW bits only if the top XW-LW+1 bits are all copies of the sign.
      assign lane_ovf = s1_arith &&
                        !((&s1_raw[XW-1:LW-1]) || !(|s1_raw[XW-1:LW-1]));

      assign ovf_n[i] = lane_ovf;
      assign res_n[i*LW +: LW] =
         (lane_ovf && s1_sat) ? (s1_raw[XW-1] ? {1'b1, {(LW-1){1'b0}}}
                                              : {1'b0, {(LW-1){1'b1}}})
                              : s1_raw[LW-1:0];
   end

   always_ff @(posedge clk) begin
      if (en1 && in_valid) begin
         s1_op  <= opcode;
         s1_sat <= sat;
      end
   end

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         ovf       <= '0;
         err       <= 1'b0;
      end else begin
         if (en1) s1_valid <= in_valid;
         if (en2) begin
            out_valid <= s1_valid;
            // A bubble clears out_valid but leaves the last result in place.
            if (s1_valid) begin
               result <= res_n;
               ovf    <= ovf_n;
               err    <= err_n;
            end
         end
      end
   end

endmodule

// File: tb/tb_exec_simd_pipe.sv
// Directed bench for exec_simd_pipe (LANES=4, LW=16): single-op vector table plus
// backpressure, back-to-back error/shift and mid-flight reset sequences.
module tb_exec_simd_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic        sat;
   logic [63:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic [3:0]  ovf;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  op;
      logic        sat;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic [3:0]  ovf;
      logic        err;
   } vec_t;

   vec_t vecs [12];

   exec_simd_pipe #(.LANES(4), .LW(16), .SHW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .sat       (sat),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [3:0] op, input logic s, input logic [63:0] va,
                          input logic [63:0] vb);
      in_valid = 1'b1;
      opcode   = op;
      sat      = s;
      a        = va;
      b        = vb;
   endtask

   // Present at cycle start, accept on the next edge, result visible after the edge after that.
   task automatic run_vec(input vec_t v, input int idx);
      out_ready = 1'b1;
      present(v.op, v.sat, v.a, v.b);
      #1;
      check($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_early_valid", idx), 64'(out_valid), 64'd0);
      tick();
      check($sformatf("v%0d_out_valid", idx), 64'(out_valid), 64'd1);
      check($sformatf("v%0d_result", idx), result, v.res);
      check($sformatf("v%0d_ovf", idx), 64'(ovf), 64'(v.ovf));
      check($sformatf("v%0d_err", idx), 64'(err), 64'(v.err));
      tick();
   endtask

   initial begin
      vecs[0]  = '{4'h0, 1'b0, 64'h0064_FFFF_0001_7FFF, 64'hFF38_FFFF_0002_0001,
                   64'hFF9C_FFFE_0003_8000, 4'b0001, 1'b0};
      vecs[1]  = '{4'h0, 1'b1, 64'h0064_FFFF_0001_7FFF, 64'hFF38_FFFF_0002_0001,
                   64'hFF9C_FFFE_0003_7FFF, 4'b0001, 1'b0};
      vecs[2]  = '{4'h2, 1'b0, 64'h8000_0002_FED4_012C, 64'hFFFF_0003_012C_012C,
                   64'h8000_0006_A070_5F90, 4'b1011, 1'b0};
      vecs[3]  = '{4'h2, 1'b1, 64'h8000_0002_FED4_012C, 64'hFFFF_0003_012C_012C,
                   64'h7FFF_0006_8000_7FFF, 4'b1011, 1'b0};
      vecs[4]  = '{4'h1, 1'b0, 64'h8000_0005_7FFF_0000, 64'h0001_0007_FFFF_8000,
                   64'h7FFF_FFFE_8000_8000, 4'b1011, 1'b0};
      vecs[5]  = '{4'h1, 1'b1, 64'h8000_0005_7FFF_0000, 64'h0001_0007_FFFF_8000,
                   64'h8000_FFFE_7FFF_7FFF, 4'b1011, 1'b0};
      vecs[6]  = '{4'h3, 1'b1, 64'hFFFF_0010_8000_0003, 64'h0001_0010_7FFF_FFFE,
                   64'h0001_0010_7FFF_0003, 4'b0000, 1'b0};
      vecs[7]  = '{4'h5, 1'b1, 64'hFFFF_0010_8000_0003, 64'h0001_0010_7FFF_FFFE,
                   64'hFFFF_0010_8000_FFFE, 4'b0000, 1'b0};
      vecs[8]  = '{4'h4, 1'b0, 64'h8000_0000_7FFF_FFFF, 64'h1234_5678_9ABC_DEF0,
                   64'h0000_0000_7FFF_0000, 4'b0000, 1'b0};
      vecs[9]  = '{4'h6, 1'b0, 64'h8000_7FFF_8000_F000, 64'h0014_000F_0000_0004,
                   64'hF800_0000_8000_FF00, 4'b0000, 1'b0};
      vecs[10] = '{4'hF, 1'b0, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF,
                   64'h0000_0000_0000_0000, 4'b0000, 1'b1};
      vecs[11] = '{4'h7, 1'b1, 64'h1111_2222_3333_4444, 64'h0001_0002_0003_0004,
                   64'h0000_0000_0000_0000, 4'b0000, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      opcode    = 4'h0;
      sat       = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      tick();

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // Backpressure: two ops fill the pipe, the third is held until the consumer drains.
      out_ready = 1'b0;
      present(4'h0, 1'b0, 64'h0004_0003_0002_0001, 64'h0028_001E_0014_000A);
      #1;
      check("bp_accept1", 64'(in_ready), 64'd1);
      tick();
      present(4'h1, 1'b0, 64'h0004_0003_0002_0001, 64'h0028_001E_0014_000A);
      #1;
      check("bp_accept2", 64'(in_ready), 64'd1);
      tick();
      present(4'h4, 1'b0, 64'hFFFF_0000_0005_8000, 64'h0);
      #1;
      check("bp_stall", 64'(in_ready), 64'd0);
      check("bp_head_valid", 64'(out_valid), 64'd1);
      check("bp_head_result", result, 64'h002C_0021_0016_000B);
      tick();
      tick();
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_result", result, 64'h002C_0021_0016_000B);
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("bp_second_valid", 64'(out_valid), 64'd1);
      check("bp_second_result", result, 64'hFFDC_FFE5_FFEE_FFF7);
      tick();
      check("bp_third_valid", 64'(out_valid), 64'd1);
      check("bp_third_result", result, 64'h0000_0000_0005_0000);
      tick();
      check("bp_drained", 64'(out_valid), 64'd0);

      // Undefined opcode followed directly by an arithmetic shift.
      present(4'hF, 1'b1, 64'h1234_1234_1234_1234, 64'h1111_1111_1111_1111);
      tick();
      present(4'h6, 1'b0, 64'h8000_8000_8000_8000, 64'h0004_0004_0004_0004);
      tick();
      in_valid = 1'b0;
      check("err_valid", 64'(out_valid), 64'd1);
      check("err_result", result, 64'd0);
      check("err_flag", 64'(err), 64'd1);
      tick();
      check("sra_valid", 64'(out_valid), 64'd1);
      check("sra_result", result, 64'hF800_F800_F800_F800);
      check("sra_err", 64'(err), 64'd0);
      tick();

      // Reset while two ops are in flight.
      out_ready = 1'b0;
      present(4'h0, 1'b0, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001);
      tick();
      present(4'h2, 1'b0, 64'h0002_0002_0002_0002, 64'h0003_0003_0003_0003);
      tick();
      in_valid = 1'b0;
      check("rstmid_pre_valid", 64'(out_valid), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("rstmid_async_valid", 64'(out_valid), 64'd0);
      check("rstmid_async_result", result, 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("rstmid_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rstmid_no_stale%0d", i), 64'(out_valid), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_simd_pipe.md
Name: exec_simd_pipe

Overview:
- Parametrised, pipelined successor to the fixed 4×int16 vector ALU in the GPU execute stage.
- Lane count and lane width are generic. Adds multiply, min/max, arithmetic shift, optional saturation and per-lane overflow flags.
- Two-stage pipeline with valid/ready handshakes on input and output. Sits between operand fetch and writeback, and accepts one vector op per cycle when not stalled.

Parameters:
- LANES, 4, number of signed lanes.
- LW, 16, lane width in bits (≥4, power of 2).
- SHW, 4, shift-amount width; equals log2(LW).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept this cycle.
- opcode  in  4  operation select.
- sat  in  1  1 = saturate ADD/SUB/MUL; 0 = wrap.
- a  in  LANES*LW  operand A; lane i at bits [i*LW +: LW].
- b  in  LANES*LW  operand B, same packing.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- result  out  LANES*LW  packed lane results.
- ovf  out  LANES  per-lane overflow flag.
- err  out  1  undefined opcode.

Behaviour:
- Reset: asynchronous on rst_n low. The valid bits of both stages and out_valid clear to 0, and result, ovf and err clear to 0. Reset is asynchronous; on deassertion the pipeline is empty and in_ready=1. Reset mid-operation discards all in-flight ops, and none are emitted afterwards.
- Handshake: transfer in when in_valid&&in_ready, and transfer out when out_valid&&out_ready. While out_valid=1 and out_ready=0, result/ovf/err hold stable.
- Pipeline enables:
  - en2 = !out_valid || out_ready
  - en1 = !s1_valid || en2
  - in_ready = en1 (combinational, no dependency on in_valid)
- Latency: 2 cycles when unstalled (accepted at edge N → out_valid at edge N+2). Throughput 1/cycle. When stalled, the block buffers 2 ops with no loss or reordering.
- S1 (on en1): registers opcode, sat and per-lane raw results at LW+1 bits (ADD/SUB) or 2*LW bits (MUL). s1_valid <= in_valid.
- S2 (on en2): applies saturation/truncation, computes ovf/err, loads the output registers. out_valid <= s1_valid.
- Opcodes (all lanes signed two's complement):
  - 0x0 VADD: a+b.
  - 0x1 VSUB: a−b.
  - 0x2 VMUL: a*b; low LW bits when sat=0.
  - 0x3 VMAX: max(a,b).
  - 0x4 RELU: a>0 ? a : 0; b ignored.
  - 0x5 VMIN: min(a,b).
  - 0x6 VSRA: a >>> b[SHW-1:0], arithmetic shift.
  - All other opcodes: result=0, ovf=0, err=1.
- ovf[i]=1 when the exact ADD/SUB/MUL result of lane i is outside [−2^(LW−1), 2^(LW−1)−1]. ovf is set regardless of sat, and is 0 for all other ops.
- Saturation: with sat=1 and overflow, the lane becomes 2^(LW−1)−1 if the exact result is positive, else −2^(LW−1). sat is ignored for ops 0x3–0x6.
- Lanes are fully independent; no carry crosses lanes.
- A bubble (s1_valid=0) advancing to S2 clears out_valid. Output registers then keep their prior values, and consumers must ignore them.
- Simultaneous accept and emit in the same cycle is legal and sustains full throughput.

Test Plan (LANES=4, LW=16):
- VADD, sat=0; a lanes(0..3)=0x7FFF,1,0xFFFF,100; b=1,2,0xFFFF,0xFF38 → result 0x8000,0x0003,0xFFFE,0xFF9C; ovf=4'b0001; out_valid exactly 2 cycles after accept.
- Same operands, sat=1 → lane0=0x7FFF, other lanes unchanged; ovf=4'b0001.
- VMUL, a=300,−300,2,0x8000; b=300,300,3,0xFFFF:
  - sat=0 → 0x5F90,0xA070,0x0006,0x8000; ovf=4'b1011.
  - sat=1 → 0x7FFF,0x8000,0x0006,0x7FFF.
- Backpressure: issue VADD,VSUB,RELU back-to-back with out_ready=0 → in_ready falls after 2 accepts and the third op is held. Then set out_ready=1 → results emerge in order, one per cycle, with none duplicated or dropped.
- Undefined opcode 0xF and VSRA with a=0x8000, b=4 → first op: result=0, err=1; second op: lane=0xF800, err=0.
- Assert rst_n low for 1 cycle while 2 ops are in flight → out_valid=0 immediately (asynchronous), in_ready=1 after release, and no stale op emitted.
